// File: rtl/gat_feature_reader.sv
// Feature BRAM read master: sweeps all addresses and streams them out with
// credit-based flow control. `GAT_FEATURE_ARGMAX_EN adds per-node argmax ports.
module gat_feature_reader #(
    parameter int DATA_WIDTH         = 8,
    parameter int NUM_FEATURE_OUT    = 16,
    parameter int NUM_SUBGRAPHS      = 2708,
    parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter int W_COL_WIDTH        = $clog2(NUM_FEATURE_OUT),
    parameter int RD_LATENCY         = 2,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [NEW_FEATURE_ADDR_W-1:0] feature_BRAM_addrb,
    input  logic [DATA_WIDTH-1:0]         feature_BRAM_dout,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_last
`ifdef GAT_FEATURE_ARGMAX_EN
    ,
    output logic [W_COL_WIDTH-1:0]        class_idx,
    output logic                          class_valid
`endif
);

    localparam int AW    = NEW_FEATURE_ADDR_W;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1);

    localparam logic [AW-1:0]          LAST_ADDR = AW'(NEW_FEATURE_DEPTH - 1);
    localparam logic [W_COL_WIDTH-1:0] LAST_FEAT = W_COL_WIDTH'(NUM_FEATURE_OUT - 1);
    localparam logic [CNT_W-1:0]       CREDITS   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t                 state, state_nxt;
    logic [AW-1:0]          issue_cnt, addr_q;
    logic [W_COL_WIDTH-1:0] feat_cnt;
    logic [RD_LATENCY-1:0]  vld_pipe, last_pipe;
    logic [DATA_WIDTH-1:0]  fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  fifo_last;
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]       fifo_cnt, inflight;
    logic                   issue, push, pop, start_ok, final_beat;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CNT_W'(vld_pipe[i]);
        end
    end

    // Credit covers both reads in flight and words already buffered.
    assign issue      = (state == ISSUE) && ((inflight + fifo_cnt) < CREDITS);
    assign start_ok   = (state == IDLE) && start;
    assign push       = vld_pipe[RD_LATENCY-1];
    assign m_valid    = (fifo_cnt != '0);
    assign pop        = m_valid && m_ready;
    assign m_data     = m_valid ? fifo_data[rd_ptr] : '0;
    assign m_last     = m_valid && fifo_last[rd_ptr];
    assign final_beat = pop && (fifo_cnt == CNT_W'(1)) && (inflight == '0);

    assign feature_BRAM_addrb = issue ? issue_cnt : addr_q;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = ISSUE;
            end
            ISSUE: begin
                busy = 1'b1;
                if (issue && (issue_cnt == LAST_ADDR)) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (final_beat || ((fifo_cnt == '0) && (inflight == '0))) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            addr_q    <= '0;
            feat_cnt  <= '0;
        end else if (start_ok) begin
            issue_cnt <= '0;
            addr_q    <= '0;
            feat_cnt  <= '0;
        end else if (issue) begin
            addr_q    <= issue_cnt;
            issue_cnt <= issue_cnt + AW'(1);
            feat_cnt  <= (feat_cnt == LAST_FEAT) ? '0 : feat_cnt + W_COL_WIDTH'(1);
        end
    end

    // Valid/last shift register mirrors the BRAM read pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe[0]  <= issue;
            last_pipe[0] <= (feat_cnt == LAST_FEAT);
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_data[wr_ptr] <= feature_BRAM_dout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_last <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
        end else begin
            if (push) begin
                fifo_last[wr_ptr] <= last_pipe[RD_LATENCY-1];
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

`ifdef GAT_FEATURE_ARGMAX_EN
    logic [W_COL_WIDTH-1:0]       beat_idx, best_idx, win_idx;
    logic signed [DATA_WIDTH-1:0] best_val;
    logic                         take;

    // Strict greater-than keeps the lowest index on ties.
    assign take    = (beat_idx == '0) || ($signed(m_data) > best_val);
    assign win_idx = take ? beat_idx : best_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_idx    <= '0;
            best_idx    <= '0;
            best_val    <= '0;
            class_idx   <= '0;
            class_valid <= 1'b0;
        end else begin
            class_valid <= 1'b0;
            if (start_ok) begin
                beat_idx <= '0;
            end else if (pop) begin
                if (take) begin
                    best_val <= $signed(m_data);
                    best_idx <= beat_idx;
                end
                if (m_last) begin
                    class_idx   <= win_idx;
                    class_valid <= 1'b1;
                    beat_idx    <= '0;
                end else begin
                    beat_idx <= beat_idx + W_COL_WIDTH'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_gat_feature_reader.sv
// Directed/randomized bench for gat_feature_reader with a latency-modelled BRAM.
// Argmax checks are compiled in when GAT_FEATURE_ARGMAX_EN is defined.
module tb_gat_feature_reader;

    localparam int DW    = 8;
    localparam int NF    = 4;
    localparam int NS    = 3;
    localparam int DEPTH = NS * NF;
    localparam int AW    = $clog2(DEPTH);
    localparam int WC    = $clog2(NF);
    localparam int RL    = 2;
    localparam int FD    = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] addrb;
    logic [DW-1:0] dout;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
`ifdef GAT_FEATURE_ARGMAX_EN
    logic [WC-1:0] class_idx;
    logic          class_valid;
`endif

    gat_feature_reader #(
        .DATA_WIDTH(DW), .NUM_FEATURE_OUT(NF), .NUM_SUBGRAPHS(NS),
        .RD_LATENCY(RL), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done),
        .feature_BRAM_addrb(addrb), .feature_BRAM_dout(dout),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
`ifdef GAT_FEATURE_ARGMAX_EN
        , .class_idx(class_idx), .class_valid(class_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: data appears RL cycles after the address is presented.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_pipe [RL];
    always @(posedge clk) begin
        rd_pipe[0] <= mem[addrb];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign dout = rd_pipe[RL-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Monitor state, cleared through clr.
    logic          clr = 1'b0;
    int            beats, first_valid, last_beat, done_cyc, done_cnt;
    int            busy_cnt, stall_err, max_addr, occ_err;
    logic          stalled;
    logic [DW-1:0] prev_d;
    logic          prev_l;
    logic [DW-1:0] got_d [$];
    bit            got_l [$];
    int            last_cycs [$];
    int            cls_q [$];
    int            cls_cyc [$];

    always @(negedge clk) begin
        if (clr) begin
            beats = 0; first_valid = -1; last_beat = -1; done_cyc = -1;
            done_cnt = 0; busy_cnt = 0; stall_err = 0; max_addr = -1;
            occ_err = 0; stalled = 1'b0;
            got_d.delete(); got_l.delete(); last_cycs.delete();
            cls_q.delete(); cls_cyc.delete();
        end else if (rst_n) begin
            if (busy) begin
                busy_cnt++;
                if (int'(addrb) > max_addr) max_addr = int'(addrb);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (stalled && !(m_valid && m_data === prev_d && m_last === prev_l))
                stall_err++;
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (m_valid && m_ready) begin
                got_d.push_back(m_data);
                got_l.push_back(m_last);
                beats++;
                last_beat = cyc;
                if (m_last) last_cycs.push_back(cyc);
            end
            if (max_addr + 1 - beats > FD) occ_err++;
            stalled = m_valid && !m_ready;
            prev_d  = m_data;
            prev_l  = m_last;
`ifdef GAT_FEATURE_ARGMAX_EN
            if (class_valid) begin
                cls_q.push_back(int'(class_idx));
                cls_cyc.push_back(cyc);
            end
`endif
        end
    end

    bit rdy_rand = 1'b0;
    int start_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_rand) m_ready = ($urandom_range(0, 1) != 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_mon();
        clr = 1'b1;
        @(negedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic do_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done_cnt > 0), 1);
    endtask

    // Reference: word i carries mem[i]; last on every NF-th feature.
    task automatic check_stream(input string tag);
        chk($sformatf("%s_len", tag), got_d.size(), DEPTH);
        for (int i = 0; i < DEPTH && i < got_d.size(); i++) begin
            chk($sformatf("%s_d%0d", tag, i), 32'(got_d[i]), 32'(mem[i]));
            chk($sformatf("%s_l%0d", tag, i), 32'(got_l[i]), 32'((i % NF) == NF - 1));
        end
        chk($sformatf("%s_stall", tag), stall_err, 0);
        chk($sformatf("%s_occ", tag), occ_err, 0);
        chk($sformatf("%s_done_cnt", tag), done_cnt, 1);
        chk($sformatf("%s_done_lat", tag), done_cyc - last_beat, 1);
        chk($sformatf("%s_busy_span", tag), busy_cnt, done_cyc - start_cyc);
    endtask

`ifdef GAT_FEATURE_ARGMAX_EN
    int av [DEPTH] = '{3, -2, 7, 7, -8, -1, -5, -1, 0, 0, 0, 0};

    task automatic check_cls(input string tag);
        int best;
        chk($sformatf("%s_cls_cnt", tag), cls_q.size(), NS);
        for (int n = 0; n < NS && n < cls_q.size(); n++) begin
            best = 0;
            for (int f = 1; f < NF; f++)
                if ($signed(mem[n*NF+f]) > $signed(mem[n*NF+best])) best = f;
            chk($sformatf("%s_cls%0d", tag, n), cls_q[n], best);
            if (n < last_cycs.size())
                chk($sformatf("%s_cls_t%0d", tag, n), cls_cyc[n], last_cycs[n] + 1);
        end
    endtask
`endif

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
        clear_mon();
        ticks(3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_addrb", 32'(addrb), 0);
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_data", 32'(m_data), 0);
        chk("rst_last", 32'(m_last), 0);
`ifdef GAT_FEATURE_ARGMAX_EN
        chk("rst_cls_idx", 32'(class_idx), 0);
        chk("rst_cls_vld", 32'(class_valid), 0);
`endif
        rst_n = 1'b1;
        ticks(2);

        // Full-rate sweep.
        m_ready = 1'b1;
        clear_mon();
        do_start();
        wait_done(200);
        ticks(5);
        check_stream("full");
        chk("first_lat", first_valid - start_cyc, RL + 1);
        chk("thruput", last_beat - first_valid, DEPTH - 1);

        // Random backpressure with random data.
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        rdy_rand = 1'b1;
        clear_mon();
        do_start();
        wait_done(600);
        ticks(5);
        check_stream("rand");
`ifdef GAT_FEATURE_ARGMAX_EN
        check_cls("rand");
`endif
        rdy_rand = 1'b0;

        // Long stall: only FD reads may be outstanding.
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
        m_ready = 1'b0;
        clear_mon();
        do_start();
        ticks(20);
        chk("stall_max_addr", max_addr, FD - 1);
        chk("stall_beats", beats, 0);
        chk("stall_addrb", 32'(addrb), FD - 1);
        chk("stall_valid", 32'(m_valid), 1);
        m_ready = 1'b1;
        wait_done(200);
        ticks(5);
        check_stream("stall");

        // Stray starts mid-sweep and on the done cycle.
        clear_mon();
        do_start();
        ticks(5);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 200 && !done; n++) tick();
        chk("done_pulse", 32'(done), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks(20);
        chk("ign_busy", 32'(busy), 0);
        chk("ign_beats", beats, DEPTH);
        check_stream("ign");

        // Asynchronous reset in the middle of a sweep.
        clear_mon();
        do_start();
        for (int n = 0; n < 200 && beats < 5; n++) tick();
        chk("mid_beats", beats, 5);
        rst_n = 1'b0;
        #1;
        chk("mid_valid", 32'(m_valid), 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_addrb", 32'(addrb), 0);
        chk("mid_done", done_cnt, 0);
        ticks(2);
        rst_n = 1'b1;
        ticks(2);
        chk("post_rst_done", done_cnt, 0);
        clear_mon();
        do_start();
        wait_done(200);
        ticks(5);
        check_stream("rerun");

`ifdef GAT_FEATURE_ARGMAX_EN
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(av[i]);
        rdy_rand = 1'b1;
        clear_mon();
        do_start();
        wait_done(600);
        ticks(5);
        rdy_rand = 1'b0;
        check_stream("amax");
        check_cls("amax");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
